// File: rtl/seg7_mmio_display.sv
// Memory-mapped 8-digit seven-segment display controller with a prescaled
// digit scan, per-digit enable, decimal points, hex/raw modes and blink.
module seg7_mmio_display #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wr_en_i,
   input  logic        rd_en_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] wr_data_i,
   input  logic [3:0]  wr_be_i,
   output logic [31:0] rd_data_o,
   output logic [7:0]  disp_an_o,
   output logic [7:0]  disp_seg_o
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam logic [PW-1:0] SCAN_LAST  = PW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [31:0]   dataLo_q, dataLo_d, dataHi_q, dataHi_d;
   logic [18:0]   ctrl_q, ctrl_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    idx_q, idx_d;
   logic [BW-1:0] blinkCnt_q, blinkCnt_d;
   logic          phase_q, phase_d;
   logic [7:0]    an_q, an_d, seg_q, seg_d;
   logic          scanTick, frameTick;

   function automatic logic [31:0] mergeBe(input logic [31:0] oldVal,
                                           input logic [31:0] newVal,
                                           input logic [3:0]  be);
      logic [31:0] r;
      r = oldVal;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = newVal[8*b +: 8];
      return r;
   endfunction

   // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0-F
   function automatic logic [6:0] hexSeg(input logic [3:0] n);
      case (n)
         4'h0: hexSeg = 7'h40;  4'h1: hexSeg = 7'h79;
         4'h2: hexSeg = 7'h24;  4'h3: hexSeg = 7'h30;
         4'h4: hexSeg = 7'h19;  4'h5: hexSeg = 7'h12;
         4'h6: hexSeg = 7'h02;  4'h7: hexSeg = 7'h78;
         4'h8: hexSeg = 7'h00;  4'h9: hexSeg = 7'h10;
         4'hA: hexSeg = 7'h08;  4'hB: hexSeg = 7'h03;
         4'hC: hexSeg = 7'h46;  4'hD: hexSeg = 7'h21;
         4'hE: hexSeg = 7'h06;  default: hexSeg = 7'h0E;
      endcase
   endfunction

   always_comb begin
      dataLo_d = dataLo_q;
      dataHi_d = dataHi_q;
      ctrl_d   = ctrl_q;
      if (wr_en_i) begin
         case (addr_i)
            2'd0: dataLo_d = mergeBe(dataLo_q, wr_data_i, wr_be_i);
            2'd1: dataHi_d = mergeBe(dataHi_q, wr_data_i, wr_be_i);
            2'd2: begin
               if (wr_be_i[0]) ctrl_d[7:0]   = wr_data_i[7:0];
               if (wr_be_i[1]) ctrl_d[15:8]  = wr_data_i[15:8];
               if (wr_be_i[2]) ctrl_d[18:16] = wr_data_i[18:16];
            end
            default: ;
         endcase
      end
   end

   assign scanTick  = (presc_q == SCAN_LAST);
   assign frameTick = scanTick && (idx_q == 3'd7);

   // Blink state is cleared on the very edge that disables blinking
   always_comb begin
      presc_d    = scanTick ? '0 : presc_q + 1'b1;
      idx_d      = scanTick ? idx_q + 3'd1 : idx_q;
      blinkCnt_d = blinkCnt_q;
      phase_d    = phase_q;
      if (!ctrl_d[17]) begin
         blinkCnt_d = '0;
         phase_d    = 1'b0;
      end else if (ctrl_q[17] && frameTick) begin
         if (blinkCnt_q == BLINK_LAST) begin
            blinkCnt_d = '0;
            phase_d    = ~phase_q;
         end else begin
            blinkCnt_d = blinkCnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      logic [63:0] dataAll;
      logic [7:0]  rawByte;
      logic [3:0]  nibble;
      dataAll = {dataHi_q, dataLo_q};
      rawByte = dataAll[{idx_q, 3'b000} +: 8];
      nibble  = dataLo_q[{idx_q, 2'b00} +: 4];
      an_d    = 8'hFF;
      seg_d   = 8'hFF;
      if (ctrl_q[18] && ctrl_q[idx_q] && !(ctrl_q[17] && phase_q)) begin
         an_d = ~(8'd1 << idx_q);
         if (ctrl_q[16]) seg_d = ~rawByte;
         else            seg_d = {~ctrl_q[8 + {2'b00, idx_q}], hexSeg(nibble)};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dataLo_q   <= '0;
         dataHi_q   <= '0;
         ctrl_q     <= 19'h400FF;
         presc_q    <= '0;
         idx_q      <= '0;
         blinkCnt_q <= '0;
         phase_q    <= 1'b0;
         an_q       <= 8'hFF;
         seg_q      <= 8'hFF;
      end else begin
         dataLo_q   <= dataLo_d;
         dataHi_q   <= dataHi_d;
         ctrl_q     <= ctrl_d;
         presc_q    <= presc_d;
         idx_q      <= idx_d;
         blinkCnt_q <= blinkCnt_d;
         phase_q    <= phase_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   always_comb begin
      rd_data_o = '0;
      if (rd_en_i) begin
         case (addr_i)
            2'd0:    rd_data_o = dataLo_q;
            2'd1:    rd_data_o = dataHi_q;
            2'd2:    rd_data_o = {13'd0, ctrl_q};
            default: rd_data_o = {28'd0, phase_q, idx_q};
         endcase
      end
   end

   assign disp_an_o  = an_q;
   assign disp_seg_o = seg_q;

endmodule

// File: tb/tb_seg7_mmio_display.sv
// Directed bench for seg7_mmio_display with SCAN_DIV=4, BLINK_DIV=2; a local
// edge counter predicts the scan index independently of the design.
module tb_seg7_mmio_display;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        wr_en_i, rd_en_i;
   logic [1:0]  addr_i;
   logic [31:0] wr_data_i;
   logic [3:0]  wr_be_i;
   logic [31:0] rd_data_o;
   logic [7:0]  disp_an_o, disp_seg_o;

   int errCount   = 0;
   int checkCount = 0;
   int cyc        = 0;

   seg7_mmio_display #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .rd_en_i(rd_en_i),
      .addr_i(addr_i), .wr_data_i(wr_data_i), .wr_be_i(wr_be_i),
      .rd_data_o(rd_data_o), .disp_an_o(disp_an_o), .disp_seg_o(disp_seg_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d,
                                input logic [3:0] be);
      wr_en_i = 1'b1; addr_i = a; wr_data_i = d; wr_be_i = be;
      tick();
      wr_en_i = 1'b0; wr_be_i = 4'h0;
   endtask

   task automatic readReg(input logic [1:0] a, output logic [31:0] d);
      rd_en_i = 1'b1; addr_i = a;
      #1;
      d = rd_data_o;
      rd_en_i = 1'b0;
   endtask

   // Advance until the display shows digit d (display lags the index by one edge)
   task automatic gotoDigit(input int d);
      int guard = 0;
      do begin
         tick();
         guard++;
      end while (((((cyc - 1) >> 2) & 7) != d) && guard < 40);
   endtask

   initial begin
      logic [31:0] r;
      int wrEdge, expToggle, darkBad, guard;
      wr_en_i = 0; rd_en_i = 0; addr_i = 0; wr_data_i = 0; wr_be_i = 0;
      rst_ni = 1'b0;
      @(posedge clk_i); #1;
      checkOutput("rstAn", {24'd0, disp_an_o}, 32'hFF);
      checkOutput("rstSeg", {24'd0, disp_seg_o}, 32'hFF);
      readReg(2'd3, r); checkOutput("rstStatus", r, 32'h0);
      rst_ni = 1'b1;
      cyc = 0;
      readReg(2'd2, r); checkOutput("rstCtrl", r, 32'h000400FF);
      readReg(2'd0, r); checkOutput("rstDataLo", r, 32'h0);
      tick();
      checkOutput("firstAn", {24'd0, disp_an_o}, 32'hFE);
      checkOutput("firstSeg", {24'd0, disp_seg_o}, 32'hC0);
      gotoDigit(1); checkOutput("scanAn1", {24'd0, disp_an_o}, 32'hFD);
      gotoDigit(2); checkOutput("scanAn2", {24'd0, disp_an_o}, 32'hFB);
      while (cyc < 32) tick();
      readReg(2'd3, r); checkOutput("idxWrap", r, 32'h0);

      applyStimulus(2'd0, 32'h76543210, 4'hF);
      gotoDigit(0); checkOutput("hexD0", {24'd0, disp_seg_o}, 32'hC0);
      gotoDigit(1); checkOutput("hexD1", {24'd0, disp_seg_o}, 32'hF9);
      checkOutput("hexAn1", {24'd0, disp_an_o}, 32'hFD);
      gotoDigit(7); checkOutput("hexD7", {24'd0, disp_seg_o}, 32'hF8);
      checkOutput("hexAn7", {24'd0, disp_an_o}, 32'h7F);

      applyStimulus(2'd0, 32'h0000AB00, 4'b0010);
      readReg(2'd0, r); checkOutput("sbDataLo", r, 32'h7654AB10);
      gotoDigit(2); checkOutput("sbD2", {24'd0, disp_seg_o}, 32'h83);
      gotoDigit(3); checkOutput("sbD3", {24'd0, disp_seg_o}, 32'h88);

      applyStimulus(2'd2, 32'h0004010F, 4'hF);
      readReg(2'd2, r); checkOutput("ctrlRead", r, 32'h0004010F);
      gotoDigit(5); checkOutput("maskAn5", {24'd0, disp_an_o}, 32'hFF);
      checkOutput("maskSeg5", {24'd0, disp_seg_o}, 32'hFF);
      gotoDigit(0); checkOutput("dpSeg0", {24'd0, disp_seg_o}, 32'h40);
      checkOutput("dpAn0", {24'd0, disp_an_o}, 32'hFE);

      applyStimulus(2'd2, 32'h000000FF, 4'hF);
      gotoDigit(1); checkOutput("genOffAn", {24'd0, disp_an_o}, 32'hFF);

      applyStimulus(2'd2, 32'h000600FF, 4'hF);
      wrEdge = cyc;
      expToggle = ((wrEdge / 32) + 1) * 32 + 32;
      guard = 0;
      do begin
         tick(); guard++;
         readReg(2'd3, r);
      end while (!r[3] && guard < 100);
      checkOutput("blinkPhase", {31'd0, r[3]}, 32'h1);
      checkOutput("blinkTime", cyc, expToggle);
      darkBad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (disp_an_o !== 8'hFF) darkBad++;
      end
      checkOutput("blinkDark", darkBad, 0);
      applyStimulus(2'd2, 32'h000400FF, 4'hF);
      readReg(2'd3, r); checkOutput("blinkClr", {31'd0, r[3]}, 32'h0);
      tick();
      checkOutput("blinkRelit", {24'd0, disp_an_o},
                  {24'd0, ~(8'd1 << (((cyc - 1) >> 2) & 7))});

      applyStimulus(2'd2, 32'h000500FF, 4'hF);
      applyStimulus(2'd0, 32'h0000007F, 4'hF);
      applyStimulus(2'd1, 32'h12345678, 4'hF);
      gotoDigit(0); checkOutput("rawD0", {24'd0, disp_seg_o}, 32'h80);
      gotoDigit(1); checkOutput("rawD1", {24'd0, disp_seg_o}, 32'hFF);
      checkOutput("rawAn1", {24'd0, disp_an_o}, 32'hFD);
      gotoDigit(4); checkOutput("rawD4", {24'd0, disp_seg_o}, 32'h87);
      gotoDigit(7); checkOutput("rawD7", {24'd0, disp_seg_o}, 32'hED);

      applyStimulus(2'd3, 32'hFFFFFFFF, 4'hF);
      readReg(2'd3, r); checkOutput("statusRO", r, (cyc >> 2) & 7);

      wr_en_i = 1'b1; rd_en_i = 1'b1; addr_i = 2'd2;
      wr_data_i = 32'h0004FFFF; wr_be_i = 4'hF;
      #1;
      checkOutput("rdWrOld", rd_data_o, 32'h000500FF);
      tick();
      wr_en_i = 1'b0; rd_en_i = 1'b0; wr_be_i = 4'h0;
      readReg(2'd2, r); checkOutput("rdWrNew", r, 32'h0004FFFF);
      applyStimulus(2'd2, 32'hFFFFFFFF, 4'hF);
      readReg(2'd2, r); checkOutput("ctrlRsvd", r, 32'h0007FFFF);

      applyStimulus(2'd2, 32'h000400FF, 4'hF);
      applyStimulus(2'd0, 32'hDEADBEEF, 4'hF);
      guard = 0;
      do begin
         tick(); guard++;
      end while (!((((cyc >> 2) & 7) == 5) && ((cyc & 3) == 1)) && guard < 40);
      readReg(2'd3, r); checkOutput("preRstIdx", r, 32'h5);
      checkOutput("preRstAn", {24'd0, disp_an_o}, 32'hDF);
      #1;
      rst_ni = 1'b0;
      #1;
      checkOutput("midRstAn", {24'd0, disp_an_o}, 32'hFF);
      checkOutput("midRstSeg", {24'd0, disp_seg_o}, 32'hFF);
      readReg(2'd3, r); checkOutput("midRstStatus", r, 32'h0);
      readReg(2'd0, r); checkOutput("midRstDataLo", r, 32'h0);
      readReg(2'd2, r); checkOutput("midRstCtrl", r, 32'h000400FF);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
